// File: rtl/prbs_inj_scheduler.sv
// ---------------------------------------------------------------------------
// prbs_inj_scheduler : reseeds PRBS31 lanes, warms up, then round-robin
//                      injects single-cycle error strobes at a set interval.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prbs_inj_scheduler #(
  parameter int          NUM_LANES = 7,
  parameter int          LANE_W    = 3,
  parameter logic [15:0] SAT_COUNT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [29:0]          interval,
  input  logic [15:0]          num_inj,
  input  logic [NUM_LANES-1:0] lane_mask,
  input  logic [15:0]          warmup,
  output logic [NUM_LANES-1:0] prbs_rst,
  output logic [NUM_LANES-1:0] inj_strobe,
  output logic [LANE_W-1:0]    cur_lane,
  output logic [15:0]          inj_count,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEED   = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [29:0]          interval_q, interval_n;
  logic [15:0]          num_inj_q, num_inj_n;
  logic [NUM_LANES-1:0] mask_q, mask_n;
  logic [15:0]          warmup_q, warmup_n;
  logic [29:0]          cnt, cnt_n, cnt_adv;
  logic [1:0]           seed_cnt, seed_cnt_n;
  logic [15:0]          warm_cnt, warm_cnt_n;
  logic [LANE_W-1:0]    cur_lane_n;
  logic [15:0]          inj_count_n, count_inc;
  logic [NUM_LANES-1:0] prbs_rst_n, strobe_n;
  logic                 busy_n, done_n, cfg_err_n;
  logic                 fire, finish;

  function automatic logic [LANE_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] m);
    logic [LANE_W-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (m[i]) r = LANE_W'(i);
    return r;
  endfunction

  // Next set mask bit strictly above cur, wrapping to the lowest set bit.
  function automatic logic [LANE_W-1:0] next_lane(input logic [NUM_LANES-1:0] m,
                                                  input logic [LANE_W-1:0]    cur);
    logic [LANE_W-1:0] r;
    logic              found;
    r     = lowest_lane(m);
    found = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if (!found && m[i] && (i > int'(cur))) begin
        r     = LANE_W'(i);
        found = 1'b1;
      end
    return r;
  endfunction

  // cnt holds the interval position of the current cycle; a strobe is on the
  // wire in the cycle where cnt equals the interval, so strobes are registered
  // one edge early from the advanced count.
  assign fire      = (state == S_RUN) && (cnt == interval_q);
  assign cnt_adv   = fire ? 30'd1 : cnt + 30'd1;
  assign count_inc = (inj_count == SAT_COUNT) ? inj_count : inj_count + 16'd1;
  assign finish    = fire && (num_inj_q != 16'd0) && (count_inc == num_inj_q);

  always_comb begin
    state_n     = state;
    interval_n  = interval_q;
    num_inj_n   = num_inj_q;
    mask_n      = mask_q;
    warmup_n    = warmup_q;
    cnt_n       = cnt;
    seed_cnt_n  = seed_cnt;
    warm_cnt_n  = warm_cnt;
    cur_lane_n  = cur_lane;
    inj_count_n = inj_count;
    prbs_rst_n  = '0;
    strobe_n    = '0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    cfg_err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if ((interval < 30'd2) || (lane_mask == '0)) begin
            cfg_err_n = 1'b1;
          end else begin
            interval_n  = interval;
            num_inj_n   = num_inj;
            mask_n      = lane_mask;
            warmup_n    = warmup;
            inj_count_n = 16'd0;
            cur_lane_n  = lowest_lane(lane_mask);
            seed_cnt_n  = 2'd0;
            prbs_rst_n  = lane_mask;
            busy_n      = 1'b1;
            state_n     = S_SEED;
          end
        end
      end
      S_SEED: begin
        if (stop) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else if (seed_cnt == 2'd3) begin
          busy_n = 1'b1;
          if (warmup_q == 16'd0) begin
            state_n = S_RUN;
            cnt_n   = 30'd1;
          end else begin
            state_n    = S_WARMUP;
            warm_cnt_n = 16'd1;
          end
        end else begin
          busy_n     = 1'b1;
          seed_cnt_n = seed_cnt + 2'd1;
          prbs_rst_n = mask_q;
        end
      end
      S_WARMUP: begin
        if (stop) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          busy_n = 1'b1;
          if (warm_cnt == warmup_q) begin
            state_n = S_RUN;
            cnt_n   = 30'd1;
          end else begin
            warm_cnt_n = warm_cnt + 16'd1;
          end
        end
      end
      S_RUN: begin
        if (fire) begin
          inj_count_n = count_inc;
          cur_lane_n  = next_lane(mask_q, cur_lane);
        end
        if (stop || finish) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          busy_n = 1'b1;
          cnt_n  = cnt_adv;
          if (cnt_adv == interval_q)
            strobe_n = NUM_LANES'(1) << cur_lane_n;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      interval_q <= '0;
      num_inj_q  <= '0;
      mask_q     <= '0;
      warmup_q   <= '0;
      cnt        <= '0;
      seed_cnt   <= '0;
      warm_cnt   <= '0;
      cur_lane   <= '0;
      inj_count  <= '0;
      prbs_rst   <= '0;
      inj_strobe <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      interval_q <= interval_n;
      num_inj_q  <= num_inj_n;
      mask_q     <= mask_n;
      warmup_q   <= warmup_n;
      cnt        <= cnt_n;
      seed_cnt   <= seed_cnt_n;
      warm_cnt   <= warm_cnt_n;
      cur_lane   <= cur_lane_n;
      inj_count  <= inj_count_n;
      prbs_rst   <= prbs_rst_n;
      inj_strobe <= strobe_n;
      busy       <= busy_n;
      done       <= done_n;
      cfg_err    <= cfg_err_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prbs_inj_scheduler.sv
// Bench for prbs_inj_scheduler: arithmetic run model checked every cycle,
// plus literal spot checks; a second instance uses a small saturation limit.
`default_nettype none

module tb_prbs_inj_scheduler;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [29:0] interval;
  logic [15:0] num_inj, warmup;
  logic [6:0]  lane_mask;

  logic [6:0]  prbs_rst, inj_strobe, s_prbs_rst, s_inj_strobe;
  logic [2:0]  cur_lane, s_cur_lane;
  logic [15:0] inj_count, s_inj_count;
  logic        busy, done, cfg_err, s_busy, s_done, s_cfg_err;

  prbs_inj_scheduler #(.NUM_LANES(7), .LANE_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .interval(interval),
    .num_inj(num_inj), .lane_mask(lane_mask), .warmup(warmup),
    .prbs_rst(prbs_rst), .inj_strobe(inj_strobe), .cur_lane(cur_lane),
    .inj_count(inj_count), .busy(busy), .done(done), .cfg_err(cfg_err));

  prbs_inj_scheduler #(.NUM_LANES(7), .LANE_W(3), .SAT_COUNT(16'd5)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .interval(interval),
    .num_inj(num_inj), .lane_mask(lane_mask), .warmup(warmup),
    .prbs_rst(s_prbs_rst), .inj_strobe(s_inj_strobe), .cur_lane(s_cur_lane),
    .inj_count(s_inj_count), .busy(s_busy), .done(s_done), .cfg_err(s_cfg_err));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Run descriptor: cycle in which start was sampled-high, config, stop cycle.
  longint BIG = longint'(1) << 60;
  bit     have_run = 1'b0;
  longint m_start, m_int, m_ninj, m_wu, m_stop;
  logic [6:0] m_mask;
  int     lanes[16];
  int     nl = 0;
  longint prev_cnt = 0, prev_cnt_sat = 0;
  int     prev_lane = 0;
  longint err_cyc = -10;

  function automatic longint first_t();
    return m_start + 5 + m_wu + m_int - 1;
  endfunction

  function automatic longint done_t();
    longint d;
    d = (m_ninj != 0) ? first_t() + (m_ninj - 1) * m_int + 1 : BIG;
    if (m_stop + 1 < d) d = m_stop + 1;
    return d;
  endfunction

  function automatic longint n_before(longint c);
    longint lim, f;
    lim = (c < done_t()) ? c : done_t();
    f   = first_t();
    if (lim <= f) return 0;
    return (lim - 1 - f) / m_int + 1;
  endfunction

  function automatic bit in_run(longint c);
    return have_run && (c > m_start);
  endfunction

  function automatic bit exp_busy(longint c);
    return in_run(c) && (c < done_t());
  endfunction

  function automatic bit exp_done(longint c);
    return in_run(c) && (c == done_t());
  endfunction

  function automatic logic [6:0] exp_prbs(longint c);
    return (exp_busy(c) && c <= m_start + 4) ? m_mask : 7'd0;
  endfunction

  function automatic logic [6:0] exp_strobe(longint c);
    logic [6:0] one;
    longint     f;
    one = 7'd1;
    f   = first_t();
    if (exp_busy(c) && c >= f && ((c - f) % m_int) == 0)
      return one << lanes[int'(n_before(c) % nl)];
    return 7'd0;
  endfunction

  function automatic int exp_lane(longint c);
    return in_run(c) ? lanes[int'(n_before(c) % nl)] : prev_lane;
  endfunction

  function automatic longint exp_count(longint c, longint sat);
    longint nb;
    if (!in_run(c)) return (sat == 5) ? prev_cnt_sat : prev_cnt;
    nb = n_before(c);
    return (nb > sat) ? sat : nb;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Every cycle out of reset, both instances are held against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("prbs_rst",   64'(prbs_rst),   64'(exp_prbs(cyc)));
      chk("inj_strobe", 64'(inj_strobe), 64'(exp_strobe(cyc)));
      chk("cur_lane",   64'(cur_lane),   64'(exp_lane(cyc)));
      chk("inj_count",  64'(inj_count),  64'(exp_count(cyc, 65535)));
      chk("busy",       64'(busy),       64'(exp_busy(cyc)));
      chk("done",       64'(done),       64'(exp_done(cyc)));
      chk("cfg_err",    64'(cfg_err),    64'(cyc == err_cyc + 1));
      chk("sat_count",  64'(s_inj_count), 64'(exp_count(cyc, 5)));
      chk("sat_strobe", 64'(s_inj_strobe), 64'(exp_strobe(cyc)));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input longint c);
    while (cyc < c) tick();
  endtask

  task automatic do_start(input logic [6:0] msk, input longint intv, input longint ninj,
                          input longint wu, output longint t0);
    lane_mask = msk;
    interval  = 30'(intv);
    num_inj   = 16'(ninj);
    warmup    = 16'(wu);
    start     = 1'b1;
    t0        = cyc;
    if (intv < 2 || msk == 7'd0) begin
      err_cyc = cyc;
    end else begin
      prev_lane    = exp_lane(cyc);
      prev_cnt     = exp_count(cyc, 65535);
      prev_cnt_sat = exp_count(cyc, 5);
      have_run = 1'b1;
      m_start  = cyc;
      m_mask   = msk;
      m_int    = intv;
      m_ninj   = ninj;
      m_wu     = wu;
      m_stop   = BIG;
      nl       = 0;
      for (int i = 0; i < 7; i++)
        if (msk[i]) begin
          lanes[nl] = i;
          nl++;
        end
    end
    tick();
    start     = 1'b0;
    interval  = 30'($urandom);
    num_inj   = 16'($urandom);
    warmup    = 16'($urandom);
    lane_mask = 7'($urandom);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    if (exp_busy(cyc)) m_stop = cyc;
    tick();
    stop = 1'b0;
  endtask

  longint t0;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    interval = '0; num_inj = '0; lane_mask = '0; warmup = '0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt",  64'(inj_count), 64'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Basic run: lanes 0,2; interval 10; four injections, no warm-up.
    do_start(7'b0000101, 10, 4, 0, t0);
    chk("basic_seed", 64'(prbs_rst), 64'h05);
    wait_to(t0 + 14);
    chk("basic_s1", 64'(inj_strobe), 64'h01);
    chk("basic_c14", 64'(inj_count), 64'd0);
    tick();
    chk("basic_c15", 64'(inj_count), 64'd1);
    wait_to(t0 + 20);
    start = 1'b1; interval = 30'd3; lane_mask = 7'h40;
    tick();
    start = 1'b0;
    wait_to(t0 + 24);
    chk("basic_s2", 64'(inj_strobe), 64'h04);
    wait_to(t0 + 44);
    chk("basic_busy44", 64'(busy), 64'd1);
    tick();
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_cnt", 64'(inj_count), 64'd4);
    repeat (3) tick();

    // Warm-up and wrap: lanes 1,6; warm-up 3; interval 2; three injections.
    do_start(7'b1000010, 2, 3, 3, t0);
    wait_to(t0 + 9);
    chk("wu_s1", 64'(inj_strobe), 64'h02);
    wait_to(t0 + 11);
    chk("wu_s2", 64'(inj_strobe), 64'h40);
    tick();
    chk("wu_lane12", 64'(cur_lane), 64'd1);
    wait_to(t0 + 14);
    chk("wu_done", 64'(done), 64'd1);
    chk("wu_lane", 64'(cur_lane), 64'd6);
    repeat (3) tick();

    // Rejected starts, and stop while idle.
    do_start(7'h7F, 1, 5, 0, t0);
    chk("cfg_int", 64'(cfg_err), 64'd1);
    tick();
    do_start(7'h00, 10, 5, 0, t0);
    chk("cfg_mask", 64'(cfg_err), 64'd1);
    chk("cfg_busy", 64'(busy), 64'd0);
    do_stop();
    repeat (3) tick();

    // Stop during SEED.
    do_start(7'b0000110, 5, 0, 2, t0);
    wait_to(t0 + 2);
    do_stop();
    chk("seedstop_done", 64'(done), 64'd1);
    chk("seedstop_rst", 64'(prbs_rst), 64'd0);
    repeat (3) tick();

    // Abort on the edge that would launch the third strobe.
    do_start(7'b0110000, 5, 0, 0, t0);
    wait_to(t0 + 18);
    do_stop();
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_cnt", 64'(inj_count), 64'd2);
    chk("abort_strobe", 64'(inj_strobe), 64'd0);
    repeat (3) tick();

    // Asynchronous reset in the middle of an interval.
    do_start(7'b0001000, 6, 0, 2, t0);
    wait_to(t0 + 15);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(inj_count), 64'd0);
    chk("arst_lane", 64'(cur_lane), 64'd0);
    have_run = 1'b0; prev_lane = 0; prev_cnt = 0; prev_cnt_sat = 0;
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Unlimited run after reset; small-limit instance must saturate.
    do_start(7'b0000011, 2, 0, 0, t0);
    wait_to(t0 + 70);
    chk("sat_main", 64'(inj_count), 64'd32);
    chk("sat_hold", 64'(s_inj_count), 64'd5);
    chk("sat_strb", 64'(s_inj_strobe), 64'h01);
    do_stop();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prbs_inj_scheduler.md
Name: prbs_inj_scheduler

Overview:
Sequences a bank of per-lane PRBS31 pattern generators for the SEU test. On start it reseeds the selected generators, waits a warm-up period, then issues single-cycle bit-error injection strobes to enabled lanes in round-robin order at a programmable interval. It stops after a programmed number of injections or on command. It sits between the slow-control register file and the lane generators and drives their reset and injection inputs.

Parameters:
NUM_LANES, 7, number of generator lanes controlled (1..16)
LANE_W, 3, width of cur_lane; must be at least clog2(NUM_LANES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle start request
stop  in  1  single-cycle abort request
interval  in  30  cycles between injections; valid range 2..2^30-1
num_inj  in  16  total injections to issue; 0 means unlimited
lane_mask  in  NUM_LANES  lanes taking part in the run
warmup  in  16  cycles to wait after reseed before injecting; 0 means skip
prbs_rst  out  NUM_LANES  synchronous reset to each lane generator
inj_strobe  out  NUM_LANES  one-hot, single-cycle error-injection strobe
cur_lane  out  LANE_W  index of the lane that receives the next strobe
inj_count  out  16  injections issued in the current or last run
busy  out  1  high in SEED, WARMUP and RUN
done  out  1  single-cycle pulse on run completion or abort
cfg_err  out  1  single-cycle pulse when start is rejected

Behaviour:
- Reset is asynchronous and active-high. On reset, state = IDLE and every output is 0: prbs_rst, inj_strobe, cur_lane, inj_count, busy, done, cfg_err. All internal counters and latched configuration are also 0.
- All outputs are registered.
- States: IDLE, SEED, WARMUP, RUN, DONE.
- IDLE, start=1:
  - If interval<2 or lane_mask==0: cfg_err pulses for 1 cycle and the block stays in IDLE.
  - Otherwise: latch interval, num_inj, lane_mask and warmup; clear inj_count; set cur_lane to the lowest set bit of the mask; go to SEED.
- start is ignored in every state except IDLE. Configuration inputs are don't-care after they are latched.
- SEED: prbs_rst = latched mask for exactly 4 cycles. Unmasked lanes never see a reset. Then go to WARMUP, or go straight to RUN if warmup==0.
- WARMUP: count exactly warmup cycles, then go to RUN.
- RUN:
  - The interval counter is loaded with 1 on entry and increments every cycle.
  - When counter==interval: inj_strobe[cur_lane]=1 for that cycle, counter reloads to 1, inj_count increments, and cur_lane advances to the next set mask bit above it, wrapping to the lowest set bit.
  - With a single-lane mask, cur_lane stays constant.
  - First strobe is interval-1 cycles after the first RUN cycle.
- Completion: when num_inj!=0 and a strobe makes inj_count==num_inj, go to DONE on the next cycle.
- Unlimited mode (num_inj==0): inj_count saturates at 0xFFFF; strobes continue.
- stop in SEED, WARMUP or RUN:
  - Go to DONE on the next cycle.
  - prbs_rst and inj_strobe are forced to 0 in the stop cycle; stop wins over a coincident strobe, and inj_count does not increment.
- stop in IDLE or DONE is ignored.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE. inj_count and cur_lane hold until the next accepted start.
- busy rises in the first SEED cycle and falls in the DONE cycle.
- Asserting reset in any state aborts immediately with no done pulse.

Test Plan:
- Basic run: mask=7'b0000101, interval=10, num_inj=4, warmup=0, start at cycle 0 -> prbs_rst=0000101 in cycles 1-4; RUN from cycle 5; inj_strobe in cycles 14, 24, 34, 44 on lanes 0, 2, 0, 2; inj_count=4; done in cycle 45; busy high in cycles 1-44.
- Warm-up and wrap: mask=7'b1000010, warmup=3, interval=2, num_inj=3 -> RUN at cycle 8; strobes at 9, 11, 13 on lanes 1, 6, 1; done at 14.
- Config errors: start with interval=1, then start with mask=0 -> cfg_err pulses once per attempt; busy stays 0; no prbs_rst or strobe.
- Abort: interval=5, unlimited run; assert stop in the same cycle as the 3rd strobe -> that strobe is suppressed; inj_count=2; done on the next cycle; then IDLE.
- Async reset in RUN: reset mid-interval -> all outputs 0 immediately, no done pulse; a subsequent start runs normally from SEED.
- Saturation (reduced-depth variant or forced count): unlimited mode, interval=2 -> inj_count holds at 0xFFFF and strobes continue.
